// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, runs a stall watchdog and turns
// exceptions/ERET/watchdog into a one-cycle flush plus PC redirect. PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0100,
  parameter int          STALL_TIMEOUT = 16,
  parameter int          CNT_W         = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic        excp_eret,
  input  logic [31:0] epc_in,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] new_pc,
  output logic        wdt_trip
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [15:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [CNT_W-1:0] TRIP_CNT = CNT_W'(STALL_TIMEOUT - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [5:0]       req_vec;
  logic             any_req;
  logic             wdt_fire;
  logic [31:0]      pc_nxt;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign any_req = stallreq_id | stallreq_ex | stallreq_mem;

  always_comb begin
    req_vec = 6'b000000;
    if (stallreq_mem)     req_vec = 6'b011111;
    else if (stallreq_ex) req_vec = 6'b001111;
    else if (stallreq_id) req_vec = 6'b000111;
  end

  // Stall bus is held low while in reset and during the flush cycle.
  assign stall = (rstn && state != FLUSH) ? req_vec : 6'b000000;

  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    wdt_fire   = 1'b0;
    pc_nxt     = EXC_VECTOR;
    case (state)
      RUN: begin
        cnt_nxt = '0;
        if (excp_valid) begin
          next_state = FLUSH;
          pc_nxt     = excp_eret ? epc_in : EXC_VECTOR;
        end else if (any_req) begin
          next_state = STALL;
          cnt_nxt    = sat_inc_cnt('0);
        end
      end
      STALL: begin
        if (excp_valid) begin
          next_state = FLUSH;
          cnt_nxt    = '0;
          pc_nxt     = excp_eret ? epc_in : EXC_VECTOR;
        end else if (!any_req) begin
          next_state = RUN;
          cnt_nxt    = '0;
        end else if (cnt >= TRIP_CNT) begin
          next_state = FLUSH;
          cnt_nxt    = '0;
          wdt_fire   = 1'b1;
        end else begin
          cnt_nxt = sat_inc_cnt(cnt);
        end
      end
      FLUSH: begin
        // Any exception reported now belongs to an instruction being flushed.
        next_state = RUN;
        cnt_nxt    = '0;
      end
      default: begin
        next_state = RUN;
        cnt_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= RUN;
      cnt         <= '0;
      flush       <= 1'b0;
      pc_redirect <= 1'b0;
      new_pc      <= 32'h0;
      wdt_trip    <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_nxt;
      flush       <= (next_state == FLUSH);
      pc_redirect <= (next_state == FLUSH);
      if (next_state == FLUSH) new_pc <= pc_nxt;
      wdt_trip    <= wdt_trip | wdt_fire;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_cyc <= 32'h0;
      perf_flush_cnt <= 16'h0;
    end else begin
      if (stall != 6'b000000) perf_stall_cyc <= sat_inc32(perf_stall_cyc);
      if (next_state == FLUSH && state != FLUSH) perf_flush_cnt <= sat_inc16(perf_flush_cnt);
    end
  end
`endif

endmodule
